sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 15, max cycles waited per handshake phase before abort (range 2..15).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  in  1  system clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 m0_stb / m1_stb  in  1  master request; held high, with operands stable, until that master's ack or err.
REQ-006 m0_addr / m1_addr  in  32  byte address; every 4 bytes selects one 48-bit word.
REQ-007 m0_we / m1_we  in  6  byte write enables; all zero means read.
REQ-008 m0_din / m1_din  in  48  write data.
REQ-009 m0_dout / m1_dout  out  48  registered read data; valid in the ack cycle and held until that master's next ack.
REQ-010 m0_ack / m1_ack  out  1  one-cycle completion pulse.
REQ-011 m0_err / m1_err  out  1  one-cycle timeout-abort pulse.
REQ-012 s_stb  out  1  request to SRAM controller.
REQ-013 s_addr / s_we / s_din  out  32/6/48  registered copy of the granted master's operands.
REQ-014 s_dout  in  48  controller read data.
REQ-015 s_nak  in  1  controller busy; high during access, low on the result cycle.
REQ-016 gnt  out  2  one-hot current grant; 00 when idle.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE.
REQ-018 IDLE: if any m*_stb is high, grant one master, latch its addr/we/din into s_*, set s_stb=1, set gnt, reset the phase counter and go to ISSUE; otherwise stay.
REQ-019 Arbitration SHALL be round-robin: single requester wins; with both requesting, the master not granted last wins; after reset, master 0 has priority.
REQ-020 ISSUE: on sampling s_nak=1, set s_stb=0, clear the counter and go to WAIT; otherwise hold s_stb=1.
REQ-021 WAIT: on sampling s_nak=0, capture s_dout into the grantee's m*_dout on reads only, pulse the grantee's ack and go to DONE.
REQ-022 DONE SHALL last exactly one cycle, clear gnt, ignore all requests and return to IDLE; this lets masters drop stb after ack.
REQ-023 s_stb SHALL be low in every cycle in which the controller presents its result (s_nak low after busy), so no back-to-back reissue occurs.
REQ-024 Latency: request first sampled at edge E0 gives s_stb high after E0, ack high after E0+4, IDLE after E0+5; next grant no earlier than E0+6.
REQ-025 Reads and writes SHALL have identical timing; m*_dout SHALL not change on writes.
REQ-026 The phase counter SHALL increment each cycle in ISSUE and in WAIT; when it reaches TIMEOUT without the awaited s_nak level, set s_stb=0, pulse the grantee's err (no ack, no dout update) and go to DONE.
REQ-027 The non-granted master's request SHALL stay pending, with no ack or err, until it is granted.
REQ-028 A master dropping stb mid-transaction SHALL NOT abort it; ack is still pulsed.
REQ-029 At most one ack or err SHALL be high per cycle; ack and err SHALL never be high together.
REQ-030 s_addr/s_we/s_din SHALL hold their values from grant until the next grant.

Reset
REQ-031 While rst is high, at every edge: FSM to IDLE, s_stb=0, s_addr=0, s_we=0, s_din=0, gnt=00, all ack/err=0, m0_dout=m1_dout=0, counter=0, round-robin pointer to master-0 priority.
REQ-032 Reset mid-transaction SHALL abandon it silently: no ack or err. The first grant is possible at the first edge with rst low.

Verification
REQ-033 Single read: m0 reads addr 0x10 and the controller model returns 0x0000_1234_5678 -> s_addr=0x10, s_we=0, m0_ack after E0+4, m0_dout=0x0000_1234_5678, gnt back to 00 after E0+5.
REQ-034 Simultaneous requests: m0 and m1 both request after reset -> m0 served first, then m1 granted at E0+6; a further simultaneous pair serves m0 after m1.
REQ-035 Write: m1 with we=6'b000011 and din=0xAAAA_BBBB_CCCC -> s_we=000011, s_din matches, m1_ack pulses once, m1_dout unchanged.
REQ-036 Timeout: the controller model holds s_nak=0 forever -> after TIMEOUT ISSUE cycles s_stb drops, m0_err pulses once, no ack, and the FSM returns to IDLE.
REQ-037 Reset during WAIT -> next cycle all outputs are zero, no ack or err, and a new m1 request is served normally.
REQ-038 Both masters continuously requesting for 20 transactions -> grants strictly alternate and s_stb is never high on a controller result cycle.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-master round-robin front end for a single-port SRAM controller.
// Each transaction runs IDLE -> ISSUE -> WAIT -> DONE, with a per-phase timeout abort.
module sram_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_stb,
  input  logic [31:0] m0_addr,
  input  logic [5:0]  m0_we,
  input  logic [47:0] m0_din,
  output logic [47:0] m0_dout,
  output logic        m0_ack,
  output logic        m0_err,

  input  logic        m1_stb,
  input  logic [31:0] m1_addr,
  input  logic [5:0]  m1_we,
  input  logic [47:0] m1_din,
  output logic [47:0] m1_dout,
  output logic        m1_ack,
  output logic        m1_err,

  output logic        s_stb,
  output logic [31:0] s_addr,
  output logic [5:0]  s_we,
  output logic [47:0] s_din,
  input  logic [47:0] s_dout,
  input  logic        s_nak,

  output logic [1:0]  gnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_m1_q, last_m1_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        s_stb_q, s_stb_d;
  logic [31:0] s_addr_q, s_addr_d;
  logic [5:0]  s_we_q, s_we_d;
  logic [47:0] s_din_q, s_din_d;
  logic [47:0] m0_dout_q, m0_dout_d;
  logic [47:0] m1_dout_q, m1_dout_d;
  logic        m0_ack_q, m0_ack_d;
  logic        m1_ack_q, m1_ack_d;
  logic        m0_err_q, m0_err_d;
  logic        m1_err_q, m1_err_d;

  logic        pick_m1;
  logic        phase_expired;

  // m1 wins when it is the only requester, or when both request and m0 was served last
  assign pick_m1       = m1_stb & (~m0_stb | ~last_m1_q);
  assign phase_expired = (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_m1_d = last_m1_q;
    gnt_d     = gnt_q;
    s_stb_d   = s_stb_q;
    s_addr_d  = s_addr_q;
    s_we_d    = s_we_q;
    s_din_d   = s_din_q;
    m0_dout_d = m0_dout_q;
    m1_dout_d = m1_dout_q;
    m0_ack_d  = 1'b0;
    m1_ack_d  = 1'b0;
    m0_err_d  = 1'b0;
    m1_err_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (m0_stb | m1_stb) begin
          last_m1_d = pick_m1;
          gnt_d     = pick_m1 ? 2'b10 : 2'b01;
          s_addr_d  = pick_m1 ? m1_addr : m0_addr;
          s_we_d    = pick_m1 ? m1_we : m0_we;
          s_din_d   = pick_m1 ? m1_din : m0_din;
          s_stb_d   = 1'b1;
          cnt_d     = 4'd0;
          state_d   = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (s_nak) begin
          s_stb_d = 1'b0;
          cnt_d   = 4'd0;
          state_d = ST_WAIT;
        end else if (phase_expired) begin
          s_stb_d  = 1'b0;
          m0_err_d = gnt_q[0];
          m1_err_d = gnt_q[1];
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_WAIT: begin
        if (!s_nak) begin
          if (s_we_q == 6'd0) begin
            if (gnt_q[0]) m0_dout_d = s_dout;
            if (gnt_q[1]) m1_dout_d = s_dout;
          end
          m0_ack_d = gnt_q[0];
          m1_ack_d = gnt_q[1];
          state_d  = ST_DONE;
        end else if (phase_expired) begin
          m0_err_d = gnt_q[0];
          m1_err_d = gnt_q[1];
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_DONE: begin
        // one dead cycle so the finished master can drop stb before the next grant
        gnt_d   = 2'b00;
        cnt_d   = 4'd0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      last_m1_q <= 1'b1;
      gnt_q     <= 2'b00;
      s_stb_q   <= 1'b0;
      s_addr_q  <= 32'd0;
      s_we_q    <= 6'd0;
      s_din_q   <= 48'd0;
      m0_dout_q <= 48'd0;
      m1_dout_q <= 48'd0;
      m0_ack_q  <= 1'b0;
      m1_ack_q  <= 1'b0;
      m0_err_q  <= 1'b0;
      m1_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_m1_q <= last_m1_d;
      gnt_q     <= gnt_d;
      s_stb_q   <= s_stb_d;
      s_addr_q  <= s_addr_d;
      s_we_q    <= s_we_d;
      s_din_q   <= s_din_d;
      m0_dout_q <= m0_dout_d;
      m1_dout_q <= m1_dout_d;
      m0_ack_q  <= m0_ack_d;
      m1_ack_q  <= m1_ack_d;
      m0_err_q  <= m0_err_d;
      m1_err_q  <= m1_err_d;
    end
  end

  assign gnt     = gnt_q;
  assign s_stb   = s_stb_q;
  assign s_addr  = s_addr_q;
  assign s_we    = s_we_q;
  assign s_din   = s_din_q;
  assign m0_dout = m0_dout_q;
  assign m1_dout = m1_dout_q;
  assign m0_ack  = m0_ack_q;
  assign m1_ack  = m1_ack_q;
  assign m0_err  = m0_err_q;
  assign m1_err  = m1_err_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM controller, two master drivers and a
// scoreboard monitor that checks grants, operands, latency, data and pulse rules.
module tb_sram_arbiter;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0]       mstb;
  logic [1:0][31:0] maddr;
  logic [1:0][5:0]  mwe;
  logic [1:0][47:0] mdin;
  logic [1:0][47:0] mdout;
  logic [1:0]       mack;
  logic [1:0]       merr;

  logic        s_stb;
  logic [31:0] s_addr;
  logic [5:0]  s_we;
  logic [47:0] s_din;
  logic [47:0] s_dout;
  logic        s_nak;
  logic [1:0]  gnt;

  sram_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m0_stb(mstb[0]), .m0_addr(maddr[0]), .m0_we(mwe[0]), .m0_din(mdin[0]),
    .m0_dout(mdout[0]), .m0_ack(mack[0]), .m0_err(merr[0]),
    .m1_stb(mstb[1]), .m1_addr(maddr[1]), .m1_we(mwe[1]), .m1_din(mdin[1]),
    .m1_dout(mdout[1]), .m1_ack(mack[1]), .m1_err(merr[1]),
    .s_stb(s_stb), .s_addr(s_addr), .s_we(s_we), .s_din(s_din),
    .s_dout(s_dout), .s_nak(s_nak), .gnt(gnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    bit          rd;
    logic [47:0] data;
    int          kind;   // 0 normal, 1 stall before busy, 2 stall while busy
  } resp_t;

  resp_t expq [2][$];

  int n_vec = 0;
  int n_mis = 0;
  int cyc   = 0;

  // controller behaviour knobs: mode 0 normal, 1 never busy, 2 busy forever
  int mode  = 0;
  int cfg_d = -1;
  int cfg_l = -1;

  logic             snap_rst = 1'b0;
  logic [1:0]       snap_stb;
  logic [1:0][31:0] snap_addr;
  logic [1:0][5:0]  snap_we;
  logic [1:0][47:0] snap_din;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] rdata(input logic [31:0] a);
    if (a == 32'h10) return 48'h0000_1234_5678;
    return {a[15:0] ^ 16'hA5C3, a * 32'h9E37_79B1};
  endfunction

  function automatic logic [5:0] rnd_we();
    if ($urandom_range(0, 1) == 0) return 6'd0;
    return 6'($urandom_range(1, 63));
  endfunction

  initial begin
    mstb  = '0;
    maddr = '0;
    mwe   = '0;
    mdin  = '0;
    s_nak = 1'b0;
    s_dout = 48'd0;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
    snap_rst  = rst;
    snap_stb  = mstb;
    snap_addr = maddr;
    snap_we   = mwe;
    snap_din  = mdin;
  end

  // scoreboard monitor plus controller model, evaluated on the falling edge
  int          lastg, gm, gcyc, cd, cl, c_state, c_cnt, nresp, win, lat;
  logic [1:0]  prev_gnt;
  bit          prev_resp;
  logic [47:0] mdl_dout [2];
  logic [31:0] hold_addr, c_addr;
  logic [5:0]  hold_we;
  logic [47:0] hold_din;
  resp_t       e;

  initial begin
    lastg = 1; gm = 0; gcyc = 0; cd = 0; cl = 1; c_state = 0; c_cnt = 0;
    prev_gnt = 2'b00; prev_resp = 0;
    mdl_dout[0] = '0; mdl_dout[1] = '0;
    hold_addr = '0; hold_we = '0; hold_din = '0; c_addr = '0;
    forever begin
      @(negedge clk);
      if (snap_rst) begin
        chk("rst_gnt", gnt, 0);
        chk("rst_s_stb", s_stb, 0);
        chk("rst_s_addr", s_addr, 0);
        chk("rst_s_we", s_we, 0);
        chk("rst_s_din", s_din, 0);
        chk("rst_ack_err", {mack, merr}, 0);
        chk("rst_dout0", mdout[0], 0);
        chk("rst_dout1", mdout[1], 0);
        lastg = 1; prev_gnt = 2'b00; prev_resp = 0;
        mdl_dout[0] = '0; mdl_dout[1] = '0;
        hold_addr = '0; hold_we = '0; hold_din = '0;
        expq[0].delete(); expq[1].delete();
        c_state = 0; s_nak = 1'b0; s_dout = '0;
      end else begin
        nresp = int'(mack[0]) + int'(mack[1]) + int'(merr[0]) + int'(merr[1]);
        chk("single_resp", (nresp <= 1), 1);
        if (prev_resp) begin
          chk("done_gnt_clear", gnt, 0);
          chk("done_s_stb", s_stb, 0);
        end
        if (gnt != 2'b00 && prev_gnt == 2'b00) begin
          if (snap_stb == 2'b11) win = 1 - lastg;
          else win = snap_stb[1] ? 1 : 0;
          chk("grant", gnt, (win == 1) ? 2'b10 : 2'b01);
          chk("grant_s_stb", s_stb, 1);
          chk("grant_s_addr", s_addr, snap_addr[win]);
          chk("grant_s_we", s_we, snap_we[win]);
          chk("grant_s_din", s_din, snap_din[win]);
          lastg = win; gm = win; gcyc = cyc;
          hold_addr = snap_addr[win]; hold_we = snap_we[win]; hold_din = snap_din[win];
        end else begin
          if (gnt != 2'b00) chk("grant_stable", gnt, prev_gnt);
          chk("hold_s_addr", s_addr, hold_addr);
          chk("hold_s_we", s_we, hold_we);
          chk("hold_s_din", s_din, hold_din);
        end
        for (int m = 0; m < 2; m++) begin
          if (mack[m] || merr[m]) begin
            if (expq[m].size() == 0) begin
              chk("unexpected_resp", 1, 0);
            end else begin
              e = expq[m].pop_front();
              chk("resp_master", gm, m);
              chk("resp_is_err", merr[m], e.err);
              chk("resp_s_stb_low", s_stb, 0);
              if (e.kind == 1)      lat = TIMEOUT;
              else if (e.kind == 2) lat = 1 + cd + TIMEOUT;
              else                  lat = 1 + cd + cl;
              chk("latency", cyc - gcyc, lat);
              if (!e.err && e.rd) mdl_dout[m] = e.data;
              chk("resp_dout", mdout[m], mdl_dout[m]);
            end
          end else begin
            chk("dout_hold", mdout[m], mdl_dout[m]);
          end
        end
        prev_resp = (nresp != 0);
        prev_gnt  = gnt;

        // controller: optional delay, then nak high for cl cycles, then result
        case (c_state)
          0: if (s_stb && mode != 1) begin
               cd = (cfg_d >= 0) ? cfg_d : int'($urandom_range(0, 3));
               cl = (cfg_l >= 0) ? cfg_l : int'($urandom_range(1, 4));
               c_addr = s_addr;
               c_cnt = cd;
               c_state = 1;
               if (c_cnt == 0) begin s_nak = 1'b1; c_cnt = cl; c_state = 2; end
             end
          1: begin
               c_cnt--;
               if (c_cnt == 0) begin s_nak = 1'b1; c_cnt = cl; c_state = 2; end
             end
          default: if (mode != 2) begin
               c_cnt--;
               if (c_cnt == 0) begin
                 chk("s_stb_on_result", s_stb, 0);
                 s_nak = 1'b0;
                 s_dout = rdata(c_addr);
                 c_state = 0;
               end
             end
        endcase
      end
    end
  end

  task automatic do_req(input int m, input logic [31:0] a, input logic [5:0] we,
                        input logic [47:0] din, input int kind, input bit may_drop);
    resp_t r;
    bit done = 0;
    bit dropped = 0;
    int n = 0;
    r.err = (kind != 0);
    r.rd = (we == 6'd0);
    r.data = rdata(a);
    r.kind = kind;
    expq[m].push_back(r);
    maddr[m] = a; mwe[m] = we; mdin[m] = din; mstb[m] = 1'b1;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      if (mack[m] || merr[m]) done = 1;
      else if (may_drop && !dropped && gnt[m] && $urandom_range(0, 3) == 0) begin
        mstb[m] = 1'b0;
        dropped = 1;
      end
    end
    mstb[m] = 1'b0;
    if (!done) chk("req_wait_expired", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t want end", $time);
    $fatal(1);
  end

  logic [47:0] dout_before;
  int n;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // single read with the reference controller timing (ack four edges after grant)
    cfg_d = 1; cfg_l = 2;
    do_req(0, 32'h10, 6'd0, 48'd0, 0, 0);
    chk("read_0x10_data", mdout[0], 48'h0000_1234_5678);

    // simultaneous pairs after reset: m0, m1, then m0 again
    cfg_d = -1; cfg_l = -1;
    do_reset();
    fork
      do_req(0, 32'h100, 6'd0, 48'd0, 0, 0);
      do_req(1, 32'h104, 6'd0, 48'd0, 0, 0);
    join
    @(negedge clk);
    fork
      do_req(0, 32'h108, 6'd0, 48'd0, 0, 0);
      do_req(1, 32'h10C, 6'b111111, 48'h1357_9BDF_0246, 0, 0);
    join

    // m1 byte-masked write leaves m1_dout untouched
    dout_before = mdout[1];
    do_req(1, 32'h40, 6'b000011, 48'hAAAA_BBBB_CCCC, 0, 0);
    chk("write_keeps_dout", mdout[1], dout_before);

    // controller never goes busy: abort from ISSUE
    mode = 1;
    do_req(0, 32'h80, 6'd0, 48'd0, 1, 0);
    mode = 0;
    repeat (2) @(negedge clk);

    // controller stays busy: abort from WAIT, then let the controller recover
    mode = 2; cfg_d = 0;
    do_req(1, 32'h84, 6'd0, 48'd0, 2, 0);
    mode = 0; cfg_d = -1;
    repeat (8) @(negedge clk);

    // reset while the transaction sits in WAIT
    cfg_d = 0; cfg_l = 4;
    maddr[0] = 32'h200; mwe[0] = 6'd0; mdin[0] = 48'd0; mstb[0] = 1'b1;
    n = 0;
    while (!gnt[0] && n < 50) begin @(negedge clk); n++; end
    chk("rst_wait_grant", gnt[0], 1);
    repeat (2) @(negedge clk);
    rst = 1'b1; mstb[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cfg_d = -1; cfg_l = -1;
    do_req(1, 32'h204, 6'd0, 48'd0, 0, 0);

    // both masters back to back: grants must alternate
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          do_req(0, $urandom, rnd_we(), {16'($urandom), $urandom}, 0, 0);
        end
      end
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          do_req(1, $urandom, rnd_we(), {16'($urandom), $urandom}, 0, 0);
        end
      end
    join

    // random gaps and masters dropping stb after being granted
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          repeat ($urandom_range(1, 4)) @(negedge clk);
          do_req(0, $urandom, rnd_we(), {16'($urandom), $urandom}, 0, 1);
        end
      end
      begin
        for (int i = 0; i < 12; i++) begin
          repeat ($urandom_range(1, 4)) @(negedge clk);
          do_req(1, $urandom, rnd_we(), {16'($urandom), $urandom}, 0, 1);
        end
      end
    join

    repeat (4) @(negedge clk);
    chk("m0_queue_drained", expq[0].size(), 0);
    chk("m1_queue_drained", expq[1].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
